// File: rtl/softmax_row_sched.sv
// Round-robin scheduler sharing one softmax datapath among NREQ row requesters.
// Optional WAIT-state abort after TIMEOUT cycles: define SOFTMAX_ROW_SCHED_TIMEOUT_EN.
module softmax_row_sched #(
  parameter int NREQ    = 4,
  parameter int LEN     = 8,
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*LEN*IN_W-1:0]  req_data,
  output logic                      sm_valid_in,
  output logic [LEN*IN_W-1:0]       sm_in_vec,
  input  logic                      sm_valid_out,
  input  logic [LEN*OUT_W-1:0]      sm_out_vec,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [IDW-1:0]            resp_id,
  output logic [LEN*OUT_W-1:0]      resp_data,
  output logic                      resp_err,
  output logic                      busy
);

  localparam int ROW_IN_W  = LEN * IN_W;
  localparam int ROW_OUT_W = LEN * OUT_W;

  if (NREQ < 2 || TIMEOUT < 1 || IDW < $clog2(NREQ)) begin : g_param_check
    $error("softmax_row_sched: need NREQ >= 2, TIMEOUT >= 1, IDW >= clog2(NREQ)");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         cur_id;
  logic [IDW-1:0]         resp_id_q;
  logic [IDW-1:0]         gnt_id;
  logic [IDW-1:0]         idx;
  logic                   gnt_found;
  logic [NREQ-1:0]        grant;
  logic [ROW_IN_W-1:0]    gnt_row;
  logic [ROW_IN_W-1:0]    in_buf;
  logic [ROW_OUT_W-1:0]   out_buf;
  logic                   timeout_hit;

  // Rotating priority search starting just after the last granted requester.
  // Held off while rst is asserted so every output reads zero during reset.
  always_comb begin
    grant     = '0;
    gnt_id    = '0;
    gnt_found = 1'b0;
    idx       = '0;
    if (state == S_IDLE && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = IDW'((int'(rr_ptr) + k) % NREQ);
        if (!gnt_found && req_valid[idx]) begin
          gnt_found   = 1'b1;
          gnt_id      = idx;
          grant[idx]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_row = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_id == IDW'(r)) begin
        gnt_row = req_data[r*ROW_IN_W +: ROW_IN_W];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (gnt_found) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (sm_valid_out || timeout_hit) state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant stage: latch the winning row and its id, advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IDW'(NREQ - 1);
      cur_id <= '0;
      in_buf <= '0;
    end else if (state == S_IDLE && gnt_found) begin
      rr_ptr <= gnt_id;
      cur_id <= gnt_id;
      in_buf <= gnt_row;
    end
  end

  // Result stage: a real result takes precedence over a coincident timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_buf   <= '0;
      resp_id_q <= '0;
    end else if (state == S_WAIT) begin
      if (sm_valid_out) begin
        out_buf   <= sm_out_vec;
        resp_id_q <= cur_id;
      end else if (timeout_hit) begin
        out_buf   <= '0;
        resp_id_q <= cur_id;
      end
    end
  end

`ifdef SOFTMAX_ROW_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             resp_err_q;

  // wait_cnt == k during the (k+1)-th WAIT cycle, so the abort leaves WAIT after TIMEOUT cycles.
  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == S_IDLE && gnt_found) begin
        resp_err_q <= 1'b0;
      end else if (state == S_WAIT && !sm_valid_out && timeout_hit) begin
        resp_err_q <= 1'b1;
      end
    end
  end

  assign resp_err = resp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  assign req_ready   = grant;
  assign sm_valid_in = (state == S_ISSUE);
  assign sm_in_vec   = in_buf;
  assign resp_valid  = (state == S_RESP);
  assign resp_id     = resp_id_q;
  assign resp_data   = out_buf;
  assign busy        = (state != S_IDLE);

endmodule

// File: doc/softmax_row_sched.md
Name: softmax_row_sched

Overview:
Round-robin scheduler that shares one softmax datapath among NREQ row requesters, such as attention heads.
- Grants one requester at a time and latches its score row.
- Issues a single-cycle launch to the softmax unit, then waits for its result.
- Holds the normalized row in an output buffer, tagged with the requester id, until the consumer accepts it.

Parameters:
NREQ, 4, number of requesters (>=2)
LEN, 8, elements per row
IN_W, 16, score width, signed Q8.8
OUT_W, 16, probability width, unsigned Q0.16
IDW, $clog2(NREQ), requester id width
TIMEOUT, 32, max WAIT cycles before abort (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester row available
req_ready  out  NREQ  one-hot grant; row r accepted when req_valid[r]&req_ready[r]
req_data  in  NREQ*LEN*IN_W  row r at [r*LEN*IN_W +: LEN*IN_W]; element i at [i*IN_W +: IN_W] within the row
sm_valid_in  out  1  launch pulse to the softmax unit
sm_in_vec  out  LEN*IN_W  row to the softmax unit, registered
sm_valid_out  in  1  softmax result valid
sm_out_vec  in  LEN*OUT_W  softmax result row
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts the response
resp_id  out  IDW  requester index of the response
resp_data  out  LEN*OUT_W  normalized row
resp_err  out  1  response aborted by timeout (tied 0 when the optional feature is off)
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=NREQ-1 so requester 0 wins first, and all outputs and buffers are 0.
- A reset that arrives in any state aborts the row. Any later sm_valid_out is ignored because state is then IDLE.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is driven combinationally: one-hot bit g for the first requester with req_valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - It is all-zero when no requester is valid and in every other state.
  - On a grant: in_buf<=req_data[g], cur_id<=g, rr_ptr<=g, next state ISSUE.
- ISSUE:
  - sm_valid_in=1 for exactly this cycle; next state WAIT.
  - sm_in_vec=in_buf, held stable from ISSUE until the next grant.
- WAIT:
  - sm_valid_out=1 -> out_buf<=sm_out_vec, resp_id<=cur_id, next state RESP.
  - Otherwise stay in WAIT.
  - sm_valid_out is ignored in IDLE, ISSUE and RESP.
- RESP:
  - resp_valid=1; resp_data/resp_id/resp_err are held stable until resp_valid&resp_ready.
  - On that handshake: next state IDLE, resp_valid=0 the following cycle.
  - No new grant is issued while in RESP, which gives full backpressure to the requesters.
- Latency with a 1-cycle softmax unit:
  - grant at cycle T, sm_valid_in at T+1, sm_valid_out at T+2, resp_valid at T+3.
  - With resp_ready held high the next grant is at T+4, so best-case throughput is one row per 4 cycles.
- A requester is never granted again before every other requester that is continuously valid has been granted (starvation-free).
- Widths:
  - rr_ptr and cur_id are IDW bits; the round-robin search wraps from NREQ-1 to 0.
  - Data is passed through unmodified; no arithmetic is performed on rows.

Optional Feature:
Macro SOFTMAX_ROW_SCHED_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no sm_valid_out: out_buf<=0, resp_err<=1, next state RESP.
  - resp_err is cleared on the next grant.
  - An sm_valid_out on the same cycle as the timeout wins, with resp_err=0.
- Not defined: no counter, WAIT waits indefinitely, resp_err constant 0.

Test Plan:
1. Only req_valid[2]=1 with row {0x0100,0,...}; softmax model has 1-cycle latency and returns 0x1111 in all elements. Required: req_ready=4'b0100 at T, sm_valid_in=1 only at T+1 with sm_in_vec equal to the row, resp_valid at T+3 with resp_id=2 and resp_data=0x1111 in all elements.
2. req_valid=4'b1111 held, resp_ready=1. Required: grant order 0,1,2,3,0,1 at 4-cycle spacing.
3. resp_ready=0 for 5 cycles in RESP. Required: resp_valid/resp_id/resp_data stable and req_ready=0 throughout; handshake on cycle 6, then the next grant one cycle later.
4. rst pulsed during WAIT, then sm_valid_out=1 two cycles later. Required: outputs 0 immediately, busy=0, no response, and the first subsequent grant goes to requester 0.
5. sm_valid_out=1 while IDLE with no requests. Required: no state change, resp_valid stays 0.
6. With SOFTMAX_ROW_SCHED_TIMEOUT_EN defined, the softmax model never responds. Required: resp_valid exactly TIMEOUT=32 cycles after entering WAIT, resp_err=1, resp_data=0; the next row clears resp_err.
